alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
//  Iterative multiply/divide unit beside the single-cycle ALU in the EX stage.
//  Executes RV32M-style MUL/MULH/MULHU/DIV/DIVU/REM/REMU over DATA_W cycles.
//  Uses a valid/ready handshake on both sides so the pipeline can stall on busy.
//  One operation is in flight at a time.
// PARAMETERS
//  DATA_W  32  operand/result width; >=4; the iteration counter is clog2(DATA_W)+1 bits
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  arst_n       in   1       asynchronous active-low reset
//  in_valid     in   1       request valid
//  in_ready     out  1       unit can accept a request (IDLE only)
//  op           in   3       0 MUL,1 MULH,2 MULHU,3 DIV,4 DIVU,5 REM,6 REMU,7 rsvd
//  opa          in   DATA_W  operand A (multiplicand/dividend)
//  opb          in   DATA_W  operand B (multiplier/divisor)
//  out_valid    out  1       result valid, held until out_ready
//  out_ready    in   1       consumer accepts result
//  result       out  DATA_W  result word
//  div_by_zero  out  1       result came from a DIV/DIVU/REM/REMU with opb==0
//  overflow     out  1       result came from signed DIV/REM with MIN / -1
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; in_ready=1; out_valid=0; result=0;
//   div_by_zero=0; overflow=0. Counter and operand registers are cleared.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready, latch op/opa/opb on that edge.
//    Go to CALC with counter=DATA_W.
//    Special cases go straight to DONE with no CALC cycles:
//    * opb==0 on a divide op
//    * MIN/-1 on DIV/REM
//    * op==7
//  - CALC: one radix-2 step per cycle. Counter decrements each cycle.
//    When the counter reaches 1, the step completes and the FSM enters DONE.
//    Exactly DATA_W cycles are spent in CALC. in_ready=0.
//  - DONE: out_valid=1 with result/flags stable. in_ready=0.
//    On out_ready, go to IDLE the next edge and drop out_valid.
//    No new request is accepted in the same cycle as the result handshake.
//  Latency, accept edge to out_valid high:
//   DATA_W+1 clocks normally; 1 clock for special cases.
//  Multiply: use shift-add on magnitudes into a 2*DATA_W product.
//   MULH: operands are signed. Negate the product when the signs differ.
//   MUL returns product[DATA_W-1:0].
//   MULH/MULHU return product[2*DATA_W-1:DATA_W].
//   MUL low word is identical for signed and unsigned operands.
//  Divide: restoring division on magnitudes (signed for DIV/REM).
//   Quotient is negated when the operand signs differ.
//   Remainder takes the sign of the dividend.
//   Quotient truncates toward zero.
//  Divide by zero: quotient = all ones; remainder = opa; div_by_zero=1.
//  Signed overflow (opa=1<<(DATA_W-1), opb=-1):
//   DIV returns opa; REM returns 0; overflow=1.
//  op==7: result=0, both flags 0.
//  Flags are valid only while out_valid=1. Both are 0 for multiply ops.
//  in_valid while busy is ignored; the requester must hold the request.
//  Operand inputs may change after acceptance without affecting the result.
//  Reset mid-CALC or mid-DONE aborts the operation; no result is produced.
// TESTING (DATA_W=32)
//  MUL 7*-3 accepted at edge t -> out_valid at t+33, result=0xFFFFFFEB, flags 0.
//  MULH 0x80000000*0x80000000 -> 0x40000000.
//   MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
//   DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, div_by_zero=1, out_valid 1 clock after accept.
//   REMU 5/0 -> 5.
//   DIV 0x80000000/-1 -> 0x80000000, overflow=1, 1-clock latency.
//   REM of the same operands -> 0.
//  Hold out_ready=0 for 10 cycles in DONE:
//   result, flags and out_valid stay stable; in_ready stays 0.
//   in_valid pulses in that window are ignored.
//  Assert arst_n=0 mid-CALC, then release:
//   IDLE, in_ready=1, out_valid=0, and the next MUL 3*4 returns 12.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M-style multiply/divide unit: one radix-2 step per clock, one op in flight.
// Latency DATA_W+1 clocks (1 for div-by-zero, MIN/-1 and reserved op); stalls via in_ready/out_ready.
module alu_muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_REM   = 3'd5;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [DATA_W-1:0] d_q;   // multiplicand for multiplies, divisor for divides
  logic [DATA_W-1:0] hi, lo;

  logic              accept, is_div, zero_b, ovf_case, rsvd, special;
  logic              sa, sb, signed_op;
  logic [DATA_W-1:0] a_mag, b_mag, spec_res;

  assign accept    = in_valid & in_ready;
  assign is_div    = (op >= OP_DIV) && (op <= 3'd6);
  assign zero_b    = (opb == '0);
  assign ovf_case  = ((op == OP_DIV) || (op == OP_REM)) && (opa == MIN_VAL) && (&opb);
  assign rsvd      = (op == OP_RSVD);
  assign special   = (is_div & zero_b) | ovf_case | rsvd;
  assign signed_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa        = signed_op & opa[DATA_W-1];
  assign sb        = signed_op & opb[DATA_W-1];
  assign a_mag     = sa ? -opa : opa;
  assign b_mag     = sb ? -opb : opb;

  always_comb begin
    spec_res = '0;
    if (is_div && zero_b)
      spec_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : opa;
    else if (ovf_case)
      spec_res = (op == OP_DIV) ? opa : '0;
  end

  // One iteration: shift-add for multiplies, restoring subtract for divides.
  logic              is_mul_q, ge;
  logic [DATA_W:0]   mul_sum, mul_sel, shifted, diff;
  logic [DATA_W-1:0] hi_n, lo_n, final_res;
  logic [2*DATA_W-1:0] prod, prod_s;

  assign is_mul_q = (op_q <= OP_MULHU);
  assign mul_sum  = {1'b0, hi} + {1'b0, d_q};
  assign mul_sel  = lo[0] ? mul_sum : {1'b0, hi};
  assign shifted  = {hi, lo[DATA_W-1]};
  assign diff     = shifted - {1'b0, d_q};
  assign ge       = ~diff[DATA_W];

  always_comb begin
    if (is_mul_q) begin
      hi_n = mul_sel[DATA_W:1];
      lo_n = {mul_sel[0], lo[DATA_W-1:1]};
    end else begin
      hi_n = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      lo_n = {lo[DATA_W-2:0], ge};
    end
  end

  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    case (op_q)
      OP_MUL:            final_res = prod_s[DATA_W-1:0];
      OP_MULH, OP_MULHU: final_res = prod_s[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:   final_res = neg_q ? -lo_n : lo_n;
      default:           final_res = neg_q ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = special ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      d_q         <= '0;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      cnt         <= CNT_INIT;
      op_q        <= op;
      neg_q       <= (op == OP_REM) ? sa : (sa ^ sb);
      d_q         <= is_div ? b_mag : a_mag;
      hi          <= '0;
      lo          <= is_div ? a_mag : b_mag;
      result      <= special ? spec_res : '0;
      div_by_zero <= is_div & zero_b;
      overflow    <= ovf_case;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      hi  <= hi_n;
      lo  <= lo_n;
      if (cnt == CW'(1)) result <= final_res;
    end
  end

endmodule
